slow_mem_responder: RTL and testbench

SLOW_MEM_RESPONDER -- requirements
Module: slow_mem_responder

---
 rtl/slow_mem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_slow_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_mem_responder.sv
// -----------------------------------------------------------------------------
// slow_mem_responder
//
// Purpose:
//   Behavioural slow backing memory for a cache. It accepts one 128-bit line
//   request at a time and answers with a single-cycle mem_ready strobe a fixed
//   LATENCY cycles after acceptance. All transaction fields are captured at
//   acceptance, so the requester may change or drop its inputs afterwards.
//   A one-cycle GAP after each response lets the requester drop its request
//   before it can be accepted again.
//
// Parameters:
//   LATENCY    cycles from acceptance to mem_ready (1..255)
//   ADDR_BITS  line-index bits; storage holds 2^ADDR_BITS lines of 128 bits
//
// Ports:
//   clk           single clock, rising edge
//   proc_reset    asynchronous active-high reset
//   mem_read      line read request, held until mem_ready
//   mem_write     line write request, held until mem_ready
//   mem_addr      line address [31:4]; only [ADDR_BITS+3:4] is used
//   mem_wdata     write line data
//   mem_rdata     read line data, registered, holds last read value
//   mem_ready     one-cycle completion strobe, registered
//   busy          high whenever the FSM is not IDLE
//   protocol_err  sticky: a request arrived with read and write both high
//   read_count    completed reads (wraps at 2^32)
//   write_count   completed writes (wraps at 2^32)
// -----------------------------------------------------------------------------
module slow_mem_responder #(
  parameter int LATENCY   = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:4]   mem_addr,
  input  logic [127:0]  mem_wdata,
  output logic [127:0]  mem_rdata,
  output logic          mem_ready,
  output logic          busy,
  output logic          protocol_err,
  output logic [31:0]   read_count,
  output logic [31:0]   write_count
);

  localparam int LINES = 1 << ADDR_BITS;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_next_s;

  // Latched transaction
  logic [ADDR_BITS-1:0]   addr_r;
  logic [127:0]           wdata_r;
  logic                   write_r;

  // Storage (deliberately not reset)
  logic [127:0]           mem_r [LINES];

  // Combinational helpers
  logic                   req_s;
  logic                   accept_s;
  logic [ADDR_BITS-1:0]   req_idx_s;
  logic [ADDR_BITS-1:0]   rd_idx_s;
  logic                   op_write_s;
  logic                   ready_next_s;
  logic                   busy_next_s;
  logic [127:0]           rdata_next_s;

  assign req_s     = mem_read | mem_write;
  assign accept_s  = (state_r == IDLE) && req_s;
  assign req_idx_s = mem_addr[ADDR_BITS+3:4];

  // Address bits above the index only alias; fold them so they are visibly consumed.
  generate
    if (ADDR_BITS < 28) begin : g_addr_hi
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^mem_addr[31:ADDR_BITS+4];
    end
  endgenerate

  // State and latency counter register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          cnt_next_s   = CNT_LOAD;
          state_next_s = (LATENCY > 1) ? BUSY : RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        cnt_next_s = cnt_r - 8'd1;
        // "<= 1" rather than "== 1" so a corrupted zero count cannot stall for 255 cycles.
        if (cnt_r <= 8'd1) begin
          state_next_s = RESP;
        end else begin
          state_next_s = BUSY;
        end
      end
      RESP: begin
        state_next_s = GAP;
      end
      GAP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    ready_next_s = 1'b0;
    busy_next_s  = 1'b0;
    rdata_next_s = mem_rdata;
    // With LATENCY=1 RESP is entered straight from IDLE, before the latch is
    // loaded, so the op type and index must come from the live request there.
    if (state_r == IDLE) begin
      op_write_s = mem_write;
      rd_idx_s   = req_idx_s;
    end else begin
      op_write_s = write_r;
      rd_idx_s   = addr_r;
    end
    if (state_next_s == RESP) begin
      ready_next_s = 1'b1;
      if (!op_write_s) begin
        rdata_next_s = mem_r[rd_idx_s];
      end else begin
        rdata_next_s = mem_rdata;
      end
    end else begin
      ready_next_s = 1'b0;
    end
    if (state_next_s != IDLE) begin
      busy_next_s = 1'b1;
    end else begin
      busy_next_s = 1'b0;
    end
  end

  // Registered outputs: strobe, busy and read data.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      mem_rdata <= 128'd0;
    end else begin
      mem_ready <= ready_next_s;
      busy      <= busy_next_s;
      mem_rdata <= rdata_next_s;
    end
  end

  // Transaction latch: captured once at acceptance, ignored inputs afterwards.
  // Both read and write high is served as a write.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      addr_r  <= '0;
      wdata_r <= 128'd0;
      write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= req_idx_s;
      wdata_r <= mem_wdata;
      write_r <= mem_write;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      protocol_err <= 1'b0;
    end else if (accept_s && mem_read && mem_write) begin
      protocol_err <= 1'b1;
    end
  end

  // Completion counters, bumped at the edge leaving RESP; they wrap naturally.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      read_count  <= 32'd0;
      write_count <= 32'd0;
    end else if (state_r == RESP) begin
      if (write_r) begin
        write_count <= write_count + 32'd1;
      end else begin
        read_count <= read_count + 32'd1;
      end
    end
  end

  // Array write at the edge leaving RESP. A reset forces state_r to IDLE,
  // so a transaction interrupted by reset never reaches this write.
  always_ff @(posedge clk) begin
    if ((state_r == RESP) && write_r) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_slow_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_slow_mem_responder
//
// Directed self-checking bench. Two instances share clock and reset: one with
// the default LATENCY=8 and one built with LATENCY=1. Inputs are driven and
// outputs sampled on the falling edge; "cycle n" is the sample taken n rising
// edges after the acceptance edge.
// -----------------------------------------------------------------------------
module tb_slow_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic proc_reset;

  // LATENCY=8 instance
  logic          rd, wr;
  logic [31:4]   addr;
  logic [127:0]  wdata, rdata;
  logic          ready, busy, perr;
  logic [31:0]   rc, wc;

  // LATENCY=1 instance
  logic          rd1, wr1;
  logic [31:4]   addr1;
  logic [127:0]  wdata1, rdata1;
  logic          ready1, busy1, perr1;
  logic [31:0]   rc1, wc1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_rc  = 0;
  int exp_wc  = 0;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D5 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
  localparam logic [127:0] V0 = 128'h0000_0000_0000_0000_0000_0000_0000_0A05;
  localparam logic [127:0] V1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D4 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

  slow_mem_responder #(.LATENCY(8), .ADDR_BITS(8)) dut (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .mem_read     (rd),
    .mem_write    (wr),
    .mem_addr     (addr),
    .mem_wdata    (wdata),
    .mem_rdata    (rdata),
    .mem_ready    (ready),
    .busy         (busy),
    .protocol_err (perr),
    .read_count   (rc),
    .write_count  (wc)
  );

  slow_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .mem_read     (rd1),
    .mem_write    (wr1),
    .mem_addr     (addr1),
    .mem_wdata    (wdata1),
    .mem_rdata    (rdata1),
    .mem_ready    (ready1),
    .busy         (busy1),
    .protocol_err (perr1),
    .read_count   (rc1),
    .write_count  (wc1)
  );

  // One transaction on the LATENCY=8 instance. Address and data are scrambled
  // at cycle 2 to show the DUT uses latched values. The request is dropped
  // 'extra' cycles after mem_ready is first seen; 30 cycles are observed so a
  // spurious re-acceptance would show up as a second pulse.
  task automatic run_txn(input logic r, input logic w, input logic [27:0] a,
                         input logic [127:0] d, input int extra,
                         output int rdy_cyc, output int pulses,
                         output logic [127:0] rd_seen);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    rdy_cyc = -1; pulses = 0; rd_seen = 128'd0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (rdy_cyc < 0) begin
          rdy_cyc = cyc;
          rd_seen = rdata;
        end
      end
      if (cyc == 2) begin
        addr  = ~a;
        wdata = ~d;
      end
      if (rdy_cyc >= 0 && cyc >= rdy_cyc + extra) begin
        rd = 1'b0; wr = 1'b0;
      end
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", perr); end
    n_tests++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_tests++; if (rc !== 32'd0 || wc !== 32'd0) begin n_fail++; $display("FAIL reset_counts: got rc=%0d wc=%0d expected 0/0", rc, wc); end
    proc_reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, pulses;
    logic [127:0] seen;
    run_txn(1'b0, 1'b1, 28'h0000010, D1, 0, lat, pulses, seen);
    exp_wc++;
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL wr_latency: got %0d expected 8", lat); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL wr_pulses: got %0d expected 1", pulses); end
    run_txn(1'b1, 1'b0, 28'h0000010, 128'd0, 0, lat, pulses, seen);
    exp_rc++;
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL rd_latency: got %0d expected 8", lat); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL rd_pulses: got %0d expected 1", pulses); end
    n_tests++; if (seen !== D1) begin n_fail++; $display("FAIL rd_data: got %h expected %h", seen, D1); end
    n_tests++; if (rdata !== D1) begin n_fail++; $display("FAIL rd_data_held: got %h expected %h", rdata, D1); end
    n_tests++; if (wc !== 32'd1 || rc !== 32'd1) begin n_fail++; $display("FAIL wr_rd_counts: got rc=%0d wc=%0d expected 1/1", rc, wc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_hold();
    int lat, pulses;
    logic [127:0] seen;
    run_txn(1'b1, 1'b0, 28'h0000010, 128'd0, 1, lat, pulses, seen);
    exp_rc++;
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
    n_tests++; if (rc !== 32'(exp_rc)) begin n_fail++; $display("FAIL hold_rc: got %0d expected %0d", rc, exp_rc); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    wr = 1'b1; addr = 28'h0000020; wdata = D3;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (ready) begin
        if (first < 0) begin
          first = cyc;
        end else if (second < 0) begin
          second = cyc;
          wr = 1'b0;
        end
      end
    end
    wr = 1'b0;
    exp_wc += 2;
    n_tests++; if (first !== 8) begin n_fail++; $display("FAIL b2b_first: got %0d expected 8", first); end
    n_tests++; if (second !== 18) begin n_fail++; $display("FAIL b2b_second: got %0d expected 18", second); end
    n_tests++; if (wc !== 32'(exp_wc)) begin n_fail++; $display("FAIL b2b_wc: got %0d expected %0d", wc, exp_wc); end
  endtask

  task automatic test_protocol_err();
    int lat, pulses;
    logic [127:0] seen;
    run_txn(1'b1, 1'b1, 28'h0000030, 128'hFF, 0, lat, pulses, seen);
    exp_wc++;
    n_tests++; if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b expected 1", perr); end
    n_tests++; if (wc !== 32'(exp_wc) || rc !== 32'(exp_rc)) begin n_fail++; $display("FAIL perr_counts: got rc=%0d wc=%0d expected %0d/%0d", rc, wc, exp_rc, exp_wc); end
    n_tests++; if (seen !== D1) begin n_fail++; $display("FAIL perr_rdata_held: got %h expected %h", seen, D1); end
    run_txn(1'b1, 1'b0, 28'h0000030, 128'd0, 0, lat, pulses, seen);
    exp_rc++;
    n_tests++; if (seen !== 128'hFF) begin n_fail++; $display("FAIL perr_wrote: got %h expected ff", seen); end
    n_tests++; if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b expected 1", perr); end
  endtask

  task automatic test_alias();
    int lat, pulses;
    logic [127:0] seen;
    run_txn(1'b0, 1'b1, 28'h0000100, D5, 0, lat, pulses, seen);
    exp_wc++;
    run_txn(1'b1, 1'b0, 28'h0000000, 128'd0, 0, lat, pulses, seen);
    exp_rc++;
    n_tests++; if (seen !== D5) begin n_fail++; $display("FAIL alias_000: got %h expected %h", seen, D5); end
    run_txn(1'b1, 1'b0, 28'hFFFFF00, 128'd0, 0, lat, pulses, seen);
    exp_rc++;
    n_tests++; if (seen !== D5) begin n_fail++; $display("FAIL alias_fff00: got %h expected %h", seen, D5); end
    n_tests++; if (rc !== 32'(exp_rc) || wc !== 32'(exp_wc)) begin n_fail++; $display("FAIL alias_counts: got rc=%0d wc=%0d expected %0d/%0d", rc, wc, exp_rc, exp_wc); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic [127:0] seen;
    logic saw;
    run_txn(1'b0, 1'b1, 28'h0000005, V0, 0, lat, pulses, seen);
    saw = 1'b0;
    @(negedge clk);
    wr = 1'b1; addr = 28'h0000005; wdata = V1;
    repeat (3) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    #2;
    proc_reset = 1'b1;
    wr = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got busy=%b ready=%b expected 0/0", busy, ready); end
    n_tests++; if (rc !== 32'd0 || wc !== 32'd0 || perr !== 1'b0) begin n_fail++; $display("FAIL rst_async_state: got rc=%0d wc=%0d perr=%b expected 0/0/0", rc, wc, perr); end
    n_tests++; if (rdata !== 128'd0) begin n_fail++; $display("FAIL rst_async_rdata: got %h expected 0", rdata); end
    @(negedge clk);
    proc_reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rst_no_ready: got %b expected 0", saw); end
    run_txn(1'b1, 1'b0, 28'h0000005, 128'd0, 0, lat, pulses, seen);
    n_tests++; if (seen !== V0) begin n_fail++; $display("FAIL rst_no_write: got %h expected %h", seen, V0); end
    n_tests++; if (rc !== 32'd1 || wc !== 32'd0) begin n_fail++; $display("FAIL rst_counts: got rc=%0d wc=%0d expected 1/0", rc, wc); end
  endtask

  task automatic test_latency1();
    @(negedge clk);
    wr1 = 1'b1; addr1 = 28'h0000007; wdata1 = D4;
    @(negedge clk);
    n_tests++; if (ready1 !== 1'b1 || busy1 !== 1'b1) begin n_fail++; $display("FAIL l1_cyc1: got ready=%b busy=%b expected 1/1", ready1, busy1); end
    wr1 = 1'b0;
    @(negedge clk);
    n_tests++; if (ready1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL l1_cyc2: got ready=%b busy=%b expected 0/1", ready1, busy1); end
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b0 || wc1 !== 32'd1) begin n_fail++; $display("FAIL l1_cyc3: got busy=%b wc=%0d expected 0/1", busy1, wc1); end
    rd1 = 1'b1; addr1 = 28'h0000007;
    @(negedge clk);
    n_tests++; if (ready1 !== 1'b1 || rdata1 !== D4) begin n_fail++; $display("FAIL l1_read: got ready=%b data=%h expected 1/%h", ready1, rdata1, D4); end
    rd1 = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (rc1 !== 32'd1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL l1_rc: got rc=%0d busy=%b expected 1/0", rc1, busy1); end
  endtask

  initial begin
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    proc_reset = 1'b1;
    test_reset();
    test_write_read();
    test_hold();
    test_back_to_back();
    test_protocol_err();
    test_alias();
    test_reset_mid();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
